// File: rtl/vga_tile_fb.sv
// rtl/vga_tile_fb.sv - memory-mapped 20x15 tile frame buffer with clear engine and pixel clock divider
// Optional macro FB_READBACK_EN enables CPU readback of tile contents.
module vga_tile_fb #(
    parameter logic [31:0] FB_BASE = 32'h0000_0400,
    parameter int          NTILES  = 300,
    parameter int          PIX_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        fb_hit,
    input  logic [8:0]  vaddr,
    output logic [7:0]  vdata,
    output logic        pixel_clk,
    output logic        busy
);

    localparam int          HALF     = PIX_DIV / 2;
    localparam int          DIV_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [29:0] NT_WORD  = 30'(NTILES);
    localparam logic [8:0]  LAST_IDX = 9'(NTILES - 1);
    localparam logic [9:0]  NT_VADDR = 10'(NTILES);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state, state_n;
    logic [8:0]  cnt, cnt_n;
    logic [7:0]  fill, fill_n;
    logic        clr_wr;
    logic [7:0]  tile [NTILES];

    logic [31:0] off;
    logic [29:0] word;
    logic [8:0]  tile_idx;
    logic        tile_hit, ctrl_hit;
    logic        cpu_tile_wr, ctrl_start;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [DIV_W-1:0] div_cnt;
    logic        unused_bits;

    // Addresses below FB_BASE wrap to a huge word offset and miss both windows
    assign off         = a - FB_BASE;
    assign word        = off[31:2];
    assign tile_idx    = off[10:2];
    assign tile_hit    = (word < NT_WORD);
    assign ctrl_hit    = (word == NT_WORD);
    assign fb_hit      = tile_hit | ctrl_hit;
    assign unused_bits = ^{off[1:0], wd[31:16]};

    assign cpu_tile_wr = we & tile_hit;
    assign ctrl_start  = we & ctrl_hit & wd[0];
    assign busy        = (state == CLEAR);

    always_comb begin
        rd = 32'h0;
`ifdef FB_READBACK_EN
        if (tile_hit)
            rd = {24'h0, tile[tile_idx]};
`endif
        if (ctrl_hit)
            rd = {30'h0, busy, 1'b0};
    end

    // A CPU tile write owns the single write port; the clear engine holds cnt that cycle
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fill_n  = fill;
        clr_wr  = 1'b0;
        if (ctrl_start) begin
            fill_n  = wd[15:8];
            cnt_n   = 9'd0;
            state_n = CLEAR;
        end else if (state == CLEAR && !cpu_tile_wr) begin
            clr_wr = 1'b1;
            if (cnt == LAST_IDX) begin
                cnt_n   = 9'd0;
                state_n = IDLE;
            end else begin
                cnt_n = cnt + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 9'd0;
            fill  <= 8'h00;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            fill  <= fill_n;
        end
    end

    assign wr_en   = cpu_tile_wr | clr_wr;
    assign wr_addr = cpu_tile_wr ? tile_idx : cnt;
    assign wr_data = cpu_tile_wr ? wd[7:0] : fill;

    always_ff @(posedge clk) begin
        if (wr_en)
            tile[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vdata <= 8'h00;
        else
            vdata <= ({1'b0, vaddr} < NT_VADDR) ? tile[vaddr] : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            pixel_clk <= 1'b0;
        end else if (div_cnt == DIV_W'(HALF - 1)) begin
            div_cnt   <= '0;
            pixel_clk <= ~pixel_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_tile_fb.sv
// tb/tb_vga_tile_fb.sv - scoreboard testbench for vga_tile_fb
module tb_vga_tile_fb;

    localparam int K_VDATA = 0;
    localparam int K_RD    = 1;
    localparam int K_HIT   = 2;
    localparam int K_BUSY  = 3;
    localparam int K_PCLK  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        fb_hit;
    logic [8:0]  vaddr;
    logic [7:0]  vdata;
    logic        pixel_clk;
    logic        busy;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   len_q[$];
    int   errors = 0;
    int   checks = 0;
    int   run    = 0;
    exp_t e;
    logic [31:0] act;
    logic [31:0] tile_rd_exp;

    vga_tile_fb dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .a         (a),
        .wd        (wd),
        .rd        (rd),
        .fb_hit    (fb_hit),
        .vaddr     (vaddr),
        .vdata     (vdata),
        .pixel_clk (pixel_clk),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Monitor: drains pending expectations and measures busy pulse lengths
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_VDATA: act = {24'h0, vdata};
                K_RD:    act = rd;
                K_HIT:   act = {31'h0, fb_hit};
                K_BUSY:  act = {31'h0, busy};
                default: act = {31'h0, pixel_clk};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
        if (reset) begin
            run = 0;
        end else if (busy === 1'b1) begin
            run++;
        end else if (run > 0) begin
            checks++;
            if (len_q.size() == 0) begin
                errors++;
                $display("FAIL busy_len: got %0d cycles expected no busy pulse", run);
            end else if (run != len_q[0]) begin
                errors++;
                $display("FAIL busy_len: got %0d cycles expected %0d", run, len_q[0]);
                void'(len_q.pop_front());
            end else begin
                void'(len_q.pop_front());
            end
            run = 0;
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int kind, input logic [31:0] v, input string name);
        exp_t x;
        x.kind = kind;
        x.exp  = v;
        x.name = name;
        exp_q.push_back(x);
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
        we = 1'b1;
        a  = addr;
        wd = data;
        step();
        we = 1'b0;
        a  = 32'h0;
        wd = 32'h0;
    endtask

    task automatic chk_tile(input logic [8:0] idx, input logic [7:0] v, input string name);
        vaddr = idx;
        step();
        push_exp(K_VDATA, {24'h0, v}, name);
    endtask

    initial begin
`ifdef FB_READBACK_EN
        tile_rd_exp = 32'h0000_00AB;
`else
        tile_rd_exp = 32'h0;
`endif
        reset = 1'b1;
        we    = 1'b0;
        a     = 32'h0;
        wd    = 32'h0;
        vaddr = 9'd0;
        step(2);
        push_exp(K_VDATA, 32'h0, "rst_vdata");
        push_exp(K_PCLK,  32'h0, "rst_pclk");
        push_exp(K_BUSY,  32'h0, "rst_busy");
        push_exp(K_HIT,   32'h0, "rst_hit_a0");
        step();
        reset = 1'b0;
        step();
        push_exp(K_PCLK, 32'h1, "pclk_t1");
        step();
        push_exp(K_PCLK, 32'h0, "pclk_t2");
        step();
        push_exp(K_PCLK, 32'h1, "pclk_t3");

        // Tile write, scanout and CPU readback of tile 1
        cpu_write(32'h0000_0404, 32'h0000_00AB);
        chk_tile(9'd1, 8'hAB, "scan_tile1");
        a = 32'h0000_0404;
        push_exp(K_HIT, 32'h1, "hit_0x404");
        push_exp(K_RD,  tile_rd_exp, "rd_0x404");
        step();
        a = 32'h0000_0406;
        push_exp(K_HIT, 32'h1, "hit_0x406");
        step();
        a = 32'h0000_03FC;
        push_exp(K_HIT, 32'h0, "hit_0x3fc");
        push_exp(K_RD,  32'h0, "rd_0x3fc");
        step();

        // Full fill with 3F
        len_q.push_back(300);
        cpu_write(32'h0000_08B0, 32'h0000_3F01);
        a = 32'h0000_08B0;
        push_exp(K_RD,  32'h2, "rd_ctrl_busy");
        push_exp(K_HIT, 32'h1, "hit_ctrl");
        push_exp(K_BUSY, 32'h1, "busy_after_start");
        step();
        a = 32'h0;
        step(299);
        push_exp(K_BUSY, 32'h0, "busy_done");
        a = 32'h0000_08B0;
        push_exp(K_RD, 32'h0, "rd_ctrl_idle");
        step();
        a = 32'h0;
        chk_tile(9'd0,   8'h3F, "fill_tile0");
        chk_tile(9'd150, 8'h3F, "fill_tile150");
        chk_tile(9'd299, 8'h3F, "fill_tile299");
        chk_tile(9'd300, 8'h00, "scan_300");
        chk_tile(9'd511, 8'h00, "scan_511");

        // Address past CTRL misses and changes nothing; CTRL with bit0 clear is ignored
        a = 32'h0000_08B4;
        push_exp(K_HIT, 32'h0, "hit_0x8b4");
        push_exp(K_RD,  32'h0, "rd_0x8b4");
        step();
        cpu_write(32'h0000_08B4, 32'h0000_0055);
        cpu_write(32'h0000_08B0, 32'h0000_FF00);
        push_exp(K_BUSY, 32'h0, "ctrl_bit0_clear");
        chk_tile(9'd45,  8'h3F, "no_alias_tile45");
        chk_tile(9'd1,   8'h3F, "no_alias_tile1");
        chk_tile(9'd299, 8'h3F, "no_alias_tile299");

        // CPU writes steal the port during a clear at cnt = 10
        len_q.push_back(302);
        cpu_write(32'h0000_08B0, 32'h0000_2A01);
        step(10);
        cpu_write(32'h0000_0414, 32'h0000_0005);
        cpu_write(32'h0000_0720, 32'h0000_0007);
        step(295);
        chk_tile(9'd5,   8'h05, "stall_tile5");
        chk_tile(9'd200, 8'h2A, "stall_tile200");
        chk_tile(9'd10,  8'h2A, "stall_tile10");
        chk_tile(9'd4,   8'h2A, "stall_tile4");

        // Restart at cnt = 100 with fill 11
        len_q.push_back(401);
        cpu_write(32'h0000_08B0, 32'h0000_7701);
        step(100);
        cpu_write(32'h0000_08B0, 32'h0000_1101);
        step(305);
        chk_tile(9'd0,   8'h11, "restart_tile0");
        chk_tile(9'd100, 8'h11, "restart_tile100");
        chk_tile(9'd150, 8'h11, "restart_tile150");
        chk_tile(9'd299, 8'h11, "restart_tile299");

        // Asynchronous reset at cnt = 50 aborts the clear
        vaddr = 9'd0;
        cpu_write(32'h0000_08B0, 32'h0000_3C01);
        step(50);
        reset = 1'b1;
        push_exp(K_BUSY,  32'h0, "abort_busy");
        push_exp(K_VDATA, 32'h0, "abort_vdata");
        push_exp(K_PCLK,  32'h0, "abort_pclk");
        step();
        reset = 1'b0;
        step();
        push_exp(K_BUSY, 32'h0, "abort_busy_after");
        chk_tile(9'd49,  8'h3C, "abort_tile49");
        chk_tile(9'd50,  8'h11, "abort_tile50");
        chk_tile(9'd299, 8'h11, "abort_tile299");
        step(2);

        checks++;
        if (len_q.size() != 0) begin
            errors++;
            $display("FAIL busy_pulses_seen: got %0d missing pulses expected 0", len_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
